// File: rtl/sad_pkg.sv
// Shared defaults and FSM state encoding for the SAD block-matching scanner.
package sad_pkg;

  localparam int SAD_FRAME_DIM = 16;
  localparam int SAD_WIN_DIM   = 4;
  localparam int SAD_PIX_W     = 8;
  localparam int SAD_AW        = 16;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    DRAIN   = 3'd2,
    COMPARE = 3'd3,
    DONE    = 3'd4
  } sad_state_t;

endpackage

// File: rtl/sad_absdiff_acc.sv
// Absolute-difference accumulator: adds |a-b| (zero-extended) each enabled cycle.
module sad_absdiff_acc #(
  parameter int PIX_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic             i_clr,
  input  logic [PIX_W-1:0] i_a,
  input  logic [PIX_W-1:0] i_b,
  output logic [31:0]      o_acc
);

  logic [PIX_W-1:0] w_diff;
  logic [31:0]      r_acc;

  assign w_diff = (i_a >= i_b) ? (i_a - i_b) : (i_b - i_a);
  assign o_acc  = r_acc;

  // Clear wins over accumulate so a new candidate always starts from zero.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_acc <= 32'd0;
    end else if (i_clr) begin
      r_acc <= 32'd0;
    end else if (i_en) begin
      r_acc <= r_acc + 32'(w_diff);
    end
  end

endmodule

// File: rtl/sad_scan_ctrl.sv
// Full-search SAD scanner: walks every window position in the frame and keeps
// the earliest lowest-SAD candidate.
module sad_scan_ctrl
  import sad_pkg::*;
#(
  parameter int FRAME_DIM = SAD_FRAME_DIM,
  parameter int WIN_DIM   = SAD_WIN_DIM,
  parameter int PIX_W     = SAD_PIX_W,
  parameter int AW        = SAD_AW
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  output logic [AW-1:0]    FrameAddr,
  input  logic [PIX_W-1:0] FrameData,
  output logic [AW-1:0]    WinAddr,
  input  logic [PIX_W-1:0] WinData,
  output logic             Busy,
  output logic             Done,
  output logic [31:0]      X,
  output logic [31:0]      Y,
  output logic [31:0]      FINALSAD
);

  localparam logic [31:0] LIM   = 32'(FRAME_DIM - WIN_DIM);
  localparam logic [31:0] WLAST = 32'(WIN_DIM - 1);
  localparam logic [31:0] FD    = 32'(FRAME_DIM);
  localparam logic [31:0] WD    = 32'(WIN_DIM);

  sad_state_t r_state;
  logic [31:0] r_x, r_y, r_i, r_j;
  logic [31:0] r_best, r_best_x, r_best_y;
  logic [31:0] r_out_x, r_out_y, r_out_sad;
  logic [AW-1:0] r_frame_addr, r_win_addr;
  logic r_valid, r_busy, r_done;

  logic w_i_wrap, w_off_last, w_x_wrap, w_cand_last, w_clr;
  logic [31:0] w_ni, w_nj, w_nx, w_ny, w_acc;
  logic [AW-1:0] w_fa_fetch, w_wa_fetch, w_fa_cand;

  assign w_i_wrap    = (r_i == WLAST);
  assign w_off_last  = w_i_wrap && (r_j == WLAST);
  assign w_ni        = w_i_wrap ? 32'd0 : r_i + 32'd1;
  assign w_nj        = w_i_wrap ? r_j + 32'd1 : r_j;
  assign w_x_wrap    = (r_x == LIM);
  assign w_cand_last = w_x_wrap && (r_y == LIM);
  assign w_nx        = w_x_wrap ? 32'd0 : r_x + 32'd1;
  assign w_ny        = w_x_wrap ? r_y + 32'd1 : r_y;
  assign w_fa_fetch  = AW'((r_y + w_nj) * FD + (r_x + w_ni));
  assign w_wa_fetch  = AW'(w_nj * WD + w_ni);
  assign w_fa_cand   = AW'(w_ny * FD + w_nx);
  // The accumulator is cleared on scan start and right after each comparison.
  assign w_clr       = (r_state == COMPARE) || ((r_state == IDLE) && Start);

  sad_absdiff_acc #(.PIX_W(PIX_W)) u_acc (
    .i_clk   (Clk),
    .i_rst_n (Reset),
    .i_en    (r_valid),
    .i_clr   (w_clr),
    .i_a     (FrameData),
    .i_b     (WinData),
    .o_acc   (w_acc)
  );

  assign FrameAddr = r_frame_addr;
  assign WinAddr   = r_win_addr;
  assign Busy      = r_busy;
  assign Done      = r_done;
  assign X         = r_out_x;
  assign Y         = r_out_y;
  assign FINALSAD  = r_out_sad;

  // Scan FSM; addresses are registered one step ahead so they are valid in every FETCH cycle.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_state      <= IDLE;
      r_x          <= 32'd0;
      r_y          <= 32'd0;
      r_i          <= 32'd0;
      r_j          <= 32'd0;
      r_best       <= 32'hFFFF_FFFF;
      r_best_x     <= 32'd0;
      r_best_y     <= 32'd0;
      r_out_x      <= 32'd0;
      r_out_y      <= 32'd0;
      r_out_sad    <= 32'd0;
      r_frame_addr <= '0;
      r_win_addr   <= '0;
      r_valid      <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_done  <= 1'b0;
      r_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (Start) begin
            r_state  <= FETCH;
            r_x      <= 32'd0;
            r_y      <= 32'd0;
            r_i      <= 32'd0;
            r_j      <= 32'd0;
            r_best   <= 32'hFFFF_FFFF;
            r_best_x <= 32'd0;
            r_best_y <= 32'd0;
            r_busy   <= 1'b1;
          end
        end
        FETCH: begin
          r_valid <= 1'b1;
          if (w_off_last) begin
            r_state      <= DRAIN;
            r_frame_addr <= '0;
            r_win_addr   <= '0;
          end else begin
            r_i          <= w_ni;
            r_j          <= w_nj;
            r_frame_addr <= w_fa_fetch;
            r_win_addr   <= w_wa_fetch;
          end
        end
        DRAIN: r_state <= COMPARE;
        COMPARE: begin
          // Strict less-than keeps the earliest candidate on ties.
          if (w_acc < r_best) begin
            r_best   <= w_acc;
            r_best_x <= r_x;
            r_best_y <= r_y;
          end
          r_i <= 32'd0;
          r_j <= 32'd0;
          if (w_cand_last) begin
            r_state <= DONE;
          end else begin
            r_state      <= FETCH;
            r_x          <= w_nx;
            r_y          <= w_ny;
            r_frame_addr <= w_fa_cand;
            r_win_addr   <= '0;
          end
        end
        DONE: begin
          r_done    <= 1'b1;
          r_busy    <= 1'b0;
          r_out_x   <= r_best_x;
          r_out_y   <= r_best_y;
          r_out_sad <= r_best;
          r_state   <= IDLE;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sad_scan_ctrl.sv
// Self-checking bench for sad_scan_ctrl: behavioural frame/window memories,
// reference SAD search model and an expected-result queue.
module tb_sad_scan_ctrl;
  import sad_pkg::*;

  localparam int FD  = 16;
  localparam int WD  = 4;
  localparam int PW  = 8;
  localparam int AW  = 16;
  localparam int LIM = FD - WD;
  localparam int SCAN_LAT = 3043;

  typedef struct {
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] sad;
    int          lat;
  } exp_t;

  exp_t sb_q[$];

  logic          Clk = 1'b0;
  logic          Reset = 1'b1;
  logic          Start = 1'b0;
  logic [PW-1:0] FrameData;
  logic [PW-1:0] WinData;
  logic [AW-1:0] FrameAddr, WinAddr;
  logic          Busy, Done;
  logic [31:0]   X, Y, FINALSAD;

  logic [PW-1:0] frame_mem [FD*FD];
  logic [PW-1:0] win_mem   [WD*WD];

  int n_checks = 0;
  int n_fail   = 0;

  sad_scan_ctrl #(.FRAME_DIM(FD), .WIN_DIM(WD), .PIX_W(PW), .AW(AW)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start),
    .FrameAddr(FrameAddr), .FrameData(FrameData),
    .WinAddr(WinAddr), .WinData(WinData),
    .Busy(Busy), .Done(Done), .X(X), .Y(Y), .FINALSAD(FINALSAD)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) begin
    FrameData <= frame_mem[FrameAddr[7:0]];
    WinData   <= win_mem[WinAddr[3:0]];
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout n_checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  task automatic fill(input logic [7:0] fv, input logic [7:0] wv);
    for (int k = 0; k < FD*FD; k++) frame_mem[k] = fv;
    for (int k = 0; k < WD*WD; k++) win_mem[k] = wv;
  endtask

  task automatic put_block(input int bx, input int by);
    fill(8'h00, 8'h00);
    for (int j = 0; j < WD; j++)
      for (int i = 0; i < WD; i++) begin
        frame_mem[(by + j) * FD + bx + i] = 8'(j * WD + i + 1);
        win_mem[j * WD + i]               = 8'(j * WD + i + 1);
      end
  endtask

  function automatic exp_t ref_model();
    exp_t r;
    int best;
    int s;
    int a;
    int b;
    best  = 32'h7FFF_FFFF;
    r.x   = 32'd0;
    r.y   = 32'd0;
    r.lat = SCAN_LAT;
    for (int cy = 0; cy <= LIM; cy++)
      for (int cx = 0; cx <= LIM; cx++) begin
        s = 0;
        for (int j = 0; j < WD; j++)
          for (int i = 0; i < WD; i++) begin
            a = int'(frame_mem[(cy + j) * FD + cx + i]);
            b = int'(win_mem[j * WD + i]);
            s += (a > b) ? a - b : b - a;
          end
        if (s < best) begin
          best = s;
          r.x  = 32'(cx);
          r.y  = 32'(cy);
        end
      end
    r.sad = 32'(best);
    return r;
  endfunction

  // Runs one scan; lat is the number of rising edges from the Start edge to Done, -1 on timeout.
  task automatic do_scan(input bit pulse_busy,
                         output logic [31:0] gx, output logic [31:0] gy, output logic [31:0] gsad,
                         output logic [31:0] mx, output logic [31:0] my, output logic [31:0] msad,
                         output int lat, output logic b1, output logic b_end, output logic dn_after);
    lat = -1;
    mx = 32'hDEAD_BEEF; my = 32'hDEAD_BEEF; msad = 32'hDEAD_BEEF; b1 = 1'b0;
    @(negedge Clk);
    Start = 1'b1;
    @(posedge Clk);
    for (int k = 0; k < 5000; k++) begin
      @(negedge Clk);
      if (k == 0) b1 = Busy;
      Start = (pulse_busy && (k == 10 || k == 1500 || k == 3042)) ? 1'b1 : 1'b0;
      if (k == 500) begin
        mx = X; my = Y; msad = FINALSAD;
      end
      if (Done === 1'b1) begin
        lat = k;
        break;
      end
    end
    Start = 1'b0;
    gx = X; gy = Y; gsad = FINALSAD; b_end = Busy;
    @(negedge Clk);
    dn_after = Done;
  endtask

  task automatic test_reset();
    #2 Reset = 1'b0;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    n_checks++; if (X !== 32'd0 || Y !== 32'd0 || FINALSAD !== 32'd0) begin n_fail++; $display("FAIL reset_outs got X=%0d Y=%0d SAD=%0d exp 0", X, Y, FINALSAD); end
    n_checks++; if (Busy !== 1'b0 || Done !== 1'b0) begin n_fail++; $display("FAIL reset_flags got busy=%b done=%b exp 0", Busy, Done); end
    n_checks++; if (FrameAddr !== 16'd0 || WinAddr !== 16'd0) begin n_fail++; $display("FAIL reset_addr got fa=%0d wa=%0d exp 0", FrameAddr, WinAddr); end
    Reset = 1'b1;
    repeat (2) @(negedge Clk);
  endtask

  task automatic test_unique();
    exp_t e, g;
    logic [31:0] gx, gy, gs, mx, my, ms;
    int lat;
    logic b1, be, dn;
    put_block(5, 7);
    sb_q.push_back('{x: 32'd5, y: 32'd7, sad: 32'd0, lat: SCAN_LAT});
    do_scan(1'b0, gx, gy, gs, mx, my, ms, lat, b1, be, dn);
    e = sb_q.pop_front();
    g = '{x: gx, y: gy, sad: gs, lat: lat};
    n_checks++; if (g.x !== e.x || g.y !== e.y) begin n_fail++; $display("FAIL unique_xy got (%0d,%0d) exp (%0d,%0d)", g.x, g.y, e.x, e.y); end
    n_checks++; if (g.sad !== e.sad) begin n_fail++; $display("FAIL unique_sad got %0d exp %0d", g.sad, e.sad); end
    n_checks++; if (g.lat != e.lat) begin n_fail++; $display("FAIL unique_latency got %0d exp %0d", g.lat, e.lat); end
    n_checks++; if (b1 !== 1'b1 || be !== 1'b0) begin n_fail++; $display("FAIL unique_busy got start=%b end=%b exp 1/0", b1, be); end
    n_checks++; if (dn !== 1'b0) begin n_fail++; $display("FAIL unique_done_pulse got %b exp 0 one cycle later", dn); end
    n_checks++; if (FrameAddr !== 16'd0 || WinAddr !== 16'd0) begin n_fail++; $display("FAIL idle_addr got fa=%0d wa=%0d exp 0", FrameAddr, WinAddr); end
  endtask

  task automatic test_ties();
    exp_t e;
    logic [31:0] gx, gy, gs, mx, my, ms;
    int lat;
    logic b1, be, dn;
    fill(8'h20, 8'h10);
    sb_q.push_back('{x: 32'd0, y: 32'd0, sad: 32'd256, lat: SCAN_LAT});
    do_scan(1'b0, gx, gy, gs, mx, my, ms, lat, b1, be, dn);
    e = sb_q.pop_front();
    n_checks++; if (gx !== e.x || gy !== e.y || gs !== e.sad) begin n_fail++; $display("FAIL ties_result got (%0d,%0d,%0d) exp (%0d,%0d,%0d)", gx, gy, gs, e.x, e.y, e.sad); end
    n_checks++; if (lat != e.lat) begin n_fail++; $display("FAIL ties_latency got %0d exp %0d", lat, e.lat); end
    n_checks++; if (mx !== 32'd5 || my !== 32'd7 || ms !== 32'd0) begin n_fail++; $display("FAIL hold_prev got (%0d,%0d,%0d) exp (5,7,0)", mx, my, ms); end
  endtask

  task automatic test_corner();
    exp_t e;
    logic [31:0] gx, gy, gs, mx, my, ms;
    int lat;
    logic b1, be, dn;
    put_block(12, 12);
    sb_q.push_back('{x: 32'd12, y: 32'd12, sad: 32'd0, lat: SCAN_LAT});
    do_scan(1'b0, gx, gy, gs, mx, my, ms, lat, b1, be, dn);
    e = sb_q.pop_front();
    n_checks++; if (gx !== e.x || gy !== e.y || gs !== e.sad) begin n_fail++; $display("FAIL corner_result got (%0d,%0d,%0d) exp (%0d,%0d,%0d)", gx, gy, gs, e.x, e.y, e.sad); end
    n_checks++; if (lat != e.lat) begin n_fail++; $display("FAIL corner_latency got %0d exp %0d", lat, e.lat); end
  endtask

  task automatic test_absdir();
    exp_t e;
    logic [31:0] gx, gy, gs, mx, my, ms;
    int lat;
    logic b1, be, dn;
    for (int d = 0; d < 2; d++) begin
      if (d == 0) fill(8'hFF, 8'h00);
      else        fill(8'h00, 8'hFF);
      sb_q.push_back('{x: 32'd0, y: 32'd0, sad: 32'd4080, lat: SCAN_LAT});
      do_scan(1'b0, gx, gy, gs, mx, my, ms, lat, b1, be, dn);
      e = sb_q.pop_front();
      n_checks++; if (gs !== e.sad || gx !== e.x || gy !== e.y) begin n_fail++; $display("FAIL absdir%0d got (%0d,%0d,%0d) exp (%0d,%0d,%0d)", d, gx, gy, gs, e.x, e.y, e.sad); end
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    logic [31:0] gx, gy, gs, mx, my, ms;
    int lat;
    int done_seen;
    logic b1, be, dn;
    put_block(5, 7);
    done_seen = 0;
    @(negedge Clk);
    Start = 1'b1;
    @(posedge Clk);
    for (int k = 0; k < 1000; k++) begin
      @(negedge Clk);
      Start = 1'b0;
      if (Done === 1'b1) done_seen++;
    end
    Reset = 1'b0;
    #1;
    n_checks++; if (X !== 32'd0 || Y !== 32'd0 || FINALSAD !== 32'd0) begin n_fail++; $display("FAIL midreset_outs got (%0d,%0d,%0d) exp 0", X, Y, FINALSAD); end
    n_checks++; if (Busy !== 1'b0 || FrameAddr !== 16'd0 || WinAddr !== 16'd0) begin n_fail++; $display("FAIL midreset_busy_addr got busy=%b fa=%0d wa=%0d exp 0", Busy, FrameAddr, WinAddr); end
    repeat (3) @(negedge Clk);
    Reset = 1'b1;
    for (int k = 0; k < 3100; k++) begin
      @(negedge Clk);
      if (Done === 1'b1) done_seen++;
    end
    n_checks++; if (done_seen != 0 || Busy !== 1'b0) begin n_fail++; $display("FAIL midreset_no_done got dones=%0d busy=%b exp 0/0", done_seen, Busy); end
    sb_q.push_back('{x: 32'd5, y: 32'd7, sad: 32'd0, lat: SCAN_LAT});
    do_scan(1'b0, gx, gy, gs, mx, my, ms, lat, b1, be, dn);
    e = sb_q.pop_front();
    n_checks++; if (gx !== e.x || gy !== e.y || gs !== e.sad || lat != e.lat) begin n_fail++; $display("FAIL restart got (%0d,%0d,%0d) lat=%0d exp (%0d,%0d,%0d) lat=%0d", gx, gy, gs, lat, e.x, e.y, e.sad, e.lat); end
  endtask

  task automatic test_busy_pulses();
    exp_t e;
    logic [31:0] gx, gy, gs, mx, my, ms;
    int lat;
    logic b1, be, dn;
    for (int k = 0; k < FD*FD; k++) frame_mem[k] = 8'($urandom_range(0, 255));
    for (int k = 0; k < WD*WD; k++) win_mem[k] = 8'($urandom_range(0, 255));
    sb_q.push_back(ref_model());
    do_scan(1'b1, gx, gy, gs, mx, my, ms, lat, b1, be, dn);
    e = sb_q.pop_front();
    n_checks++; if (gx !== e.x || gy !== e.y || gs !== e.sad) begin n_fail++; $display("FAIL pulses_result got (%0d,%0d,%0d) exp (%0d,%0d,%0d)", gx, gy, gs, e.x, e.y, e.sad); end
    n_checks++; if (lat != e.lat) begin n_fail++; $display("FAIL pulses_latency got %0d exp %0d", lat, e.lat); end
    repeat (4) @(negedge Clk);
    n_checks++; if (Busy !== 1'b0 || Done !== 1'b0) begin n_fail++; $display("FAIL pulses_idle got busy=%b done=%b exp 0/0", Busy, Done); end
  endtask

  initial begin
    fill(8'h00, 8'h00);
    test_reset();
    test_unique();
    test_ties();
    test_corner();
    test_absdir();
    test_reset_mid();
    test_busy_pulses();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
